nn_feature_averager: RTL



---
 rtl/nn_feature_averager.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/nn_feature_averager.sv
// nn_feature_averager
// -------------------
// Front-end of the NN-PLL gain block. Each PFD error pulse (err = up | dn)
// gives two samples: its width in clk cycles (instantaneous Kp) and the
// divider value N seen on the clock edge where the pulse ends. Both samples
// are averaged over a window of 2**LOG2_WIN pulses. The averages are
// published on avgn/avgkp, and avg_valid is high for one cycle when they do.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   up, dn     PFD UP/DN pulses, synchronous to clk
//   n_in       current divider value N (W bits)
//   clear      synchronous restart of the current averaging window
//   avgn       averaged N, held between updates (W bits)
//   avgkp      averaged error-pulse width, held between updates (W bits)
//   avg_valid  one-cycle strobe: new avgn/avgkp published
//   sat        at least one pulse in the published window saturated
module nn_feature_averager #(
    parameter int LOG2_WIN = 3,
    parameter int W        = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up,
    input  logic         dn,
    input  logic [W-1:0] n_in,
    input  logic         clear,
    output logic [W-1:0] avgn,
    output logic [W-1:0] avgkp,
    output logic         avg_valid,
    output logic         sat
);

    // The accumulators hold a full window of W-bit samples, so they can
    // never overflow.
    localparam int AW = W + LOG2_WIN;
    localparam logic [W-1:0]        WIDTH_MAX = '1;
    localparam logic [LOG2_WIN-1:0] CNT_LAST  = '1;

    logic                err;
    logic                err_d_q;
    logic [W-1:0]        width_q,     width_d;
    logic [LOG2_WIN-1:0] cnt_q,       cnt_d;
    logic [AW-1:0]       acc_kp_q,    acc_kp_d;
    logic [AW-1:0]       acc_n_q,     acc_n_d;
    logic                sat_acc_q,   sat_acc_d;
    logic [W-1:0]        avgn_q,      avgn_d;
    logic [W-1:0]        avgkp_q,     avgkp_d;
    logic                sat_q,       sat_d;
    logic                avg_valid_q, avg_valid_d;

    logic                sample_evt;
    logic                final_evt;
    logic [AW-1:0]       sum_kp;
    logic [AW-1:0]       sum_n;

    // A cycle with both up and dn high is still one error cycle.
    assign err = up | dn;

    // A pulse ends when err falls. The width counter still holds the full
    // pulse width at this edge.
    assign sample_evt = err_d_q & ~err;
    assign final_evt  = sample_evt & (cnt_q == CNT_LAST);

    // Window totals that include the pulse ending at this edge.
    assign sum_kp = acc_kp_q + AW'(width_q);
    assign sum_n  = acc_n_q + AW'(n_in);

    always_comb begin
        // NOTE: every signal gets a default before any branch. Without one, a
        // path that skips an assignment makes synthesis infer a latch.
        width_d     = width_q;
        cnt_d       = cnt_q;
        acc_kp_d    = acc_kp_q;
        acc_n_d     = acc_n_q;
        sat_acc_d   = sat_acc_q;
        avgn_d      = avgn_q;
        avgkp_d     = avgkp_q;
        sat_d       = sat_q;
        avg_valid_d = 1'b0;

        if (clear) begin
            // Restart the window. A pulse that ends at this edge is dropped.
            // If err is high, the rest of the pulse is measured from zero.
            width_d   = '0;
            cnt_d     = '0;
            acc_kp_d  = '0;
            acc_n_d   = '0;
            sat_acc_d = 1'b0;
        end else if (sample_evt) begin
            width_d = '0;
            if (final_evt) begin
                avgkp_d     = W'(sum_kp >> LOG2_WIN);
                avgn_d      = W'(sum_n >> LOG2_WIN);
                sat_d       = sat_acc_q | (width_q == WIDTH_MAX);
                avg_valid_d = 1'b1;
                cnt_d       = '0;
                acc_kp_d    = '0;
                acc_n_d     = '0;
                sat_acc_d   = 1'b0;
            end else begin
                acc_kp_d = sum_kp;
                acc_n_d  = sum_n;
                cnt_d    = cnt_q + LOG2_WIN'(1);
            end
        end else if (err) begin
            if (width_q != WIDTH_MAX) begin
                width_d = width_q + W'(1);
            end
            if (width_d == WIDTH_MAX) begin
                sat_acc_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // All flops then sample their inputs from before the edge, so the result
    // does not depend on the order of the statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_d_q     <= 1'b0;
            width_q     <= '0;
            cnt_q       <= '0;
            acc_kp_q    <= '0;
            acc_n_q     <= '0;
            sat_acc_q   <= 1'b0;
            avgn_q      <= '0;
            avgkp_q     <= '0;
            sat_q       <= 1'b0;
            avg_valid_q <= 1'b0;
        end else begin
            err_d_q     <= err;
            width_q     <= width_d;
            cnt_q       <= cnt_d;
            acc_kp_q    <= acc_kp_d;
            acc_n_q     <= acc_n_d;
            sat_acc_q   <= sat_acc_d;
            avgn_q      <= avgn_d;
            avgkp_q     <= avgkp_d;
            sat_q       <= sat_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avgn      = avgn_q;
    assign avgkp     = avgkp_q;
    assign avg_valid = avg_valid_q;
    assign sat       = sat_q;

endmodule
